// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Purpose:
//   Control-flow recovery sequencer for the execute stage. When a branch,
//   JAL or JALR resolves, the actual outcome (taken, target) is compared
//   against the prediction made at fetch. On a mismatch the wrong-path
//   pipeline registers are flushed and a redirect request carrying the
//   corrected PC is held towards fetch until fetch accepts it. Every
//   accepted resolved instruction also produces a one-cycle predictor
//   update record. All outputs are registered.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   ex_valid        EX holds a resolved branch/JAL/JALR this cycle
//   ex_pc           PC of the resolved instruction
//   ex_taken        actual taken outcome (1 for jumps)
//   ex_target       actual target address
//   ex_pred_taken   taken prediction made at fetch
//   ex_pred_target  target prediction made at fetch
//   redir_ready     fetch accepts the redirect this cycle
//   redir_valid     redirect request to fetch
//   redir_pc        corrected fetch PC, stable while redir_valid is high
//   flush_ifid      squash IF/ID register (every redirect cycle)
//   flush_idex      squash ID/EX register (first redirect cycle only)
//   bp_upd_valid    predictor update strobe (cycle after acceptance)
//   bp_upd_pc       PC of the updated branch
//   bp_upd_taken    actual outcome
//   bp_upd_target   actual target
//
// Optional build macro:
//   BRANCH_REDIRECT_STATS_EN - adds 32-bit outputs stat_branches (accepted
//   instructions) and stat_mispredicts (accepted mispredicts). Both wrap
//   silently and update on the acceptance edge.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
   parameter int XLEN        = 32,
   parameter int INSTR_BYTES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   input  logic            redir_ready,
`ifdef BRANCH_REDIRECT_STATS_EN
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts,
`endif
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            bp_upd_valid,
   output logic [XLEN-1:0] bp_upd_pc,
   output logic            bp_upd_taken,
   output logic [XLEN-1:0] bp_upd_target
);

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [XLEN-1:0] r_redir_pc;
   logic [XLEN-1:0] w_redir_pc_next;
   logic            r_flush_idex;
   logic            w_flush_idex_next;
   logic            r_bp_upd_valid;
   logic            w_bp_upd_valid_next;
   logic [XLEN-1:0] r_bp_upd_pc;
   logic [XLEN-1:0] w_bp_upd_pc_next;
   logic            r_bp_upd_taken;
   logic            w_bp_upd_taken_next;
   logic [XLEN-1:0] r_bp_upd_target;
   logic [XLEN-1:0] w_bp_upd_target_next;

   logic [XLEN-1:0] w_fallthru_pc;
   logic [XLEN-1:0] w_correct_pc;
   logic            w_mispredict;
   logic            w_accept;

   // Fall-through address wraps naturally at 2^XLEN through truncation.
   assign w_fallthru_pc = ex_pc + XLEN'(INSTR_BYTES);
   assign w_correct_pc  = ex_taken ? ex_target : w_fallthru_pc;

   // A target mismatch only matters when both the prediction and the
   // outcome say taken; a not-taken pair never consults the target.
   assign w_mispredict  = (ex_taken != ex_pred_taken) ||
                          (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));

   // While redirecting, EX holds wrong-path work and is ignored entirely.
   assign w_accept      = ex_valid && (r_state == ST_IDLE);

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next         = r_state;
      w_redir_pc_next      = r_redir_pc;
      w_flush_idex_next    = 1'b0;
      w_bp_upd_valid_next  = 1'b0;
      w_bp_upd_pc_next     = r_bp_upd_pc;
      w_bp_upd_taken_next  = r_bp_upd_taken;
      w_bp_upd_target_next = r_bp_upd_target;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_bp_upd_valid_next  = 1'b1;
               w_bp_upd_pc_next     = ex_pc;
               w_bp_upd_taken_next  = ex_taken;
               w_bp_upd_target_next = ex_target;
               if (w_mispredict) begin
                  w_state_next      = ST_REDIRECT;
                  w_redir_pc_next   = w_correct_pc;
                  w_flush_idex_next = 1'b1;
               end
            end
         end
         ST_REDIRECT: begin
            // redir_pc is left untouched here so it stays stable for the
            // whole handshake.
            if (redir_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_redir_pc      <= '0;
         r_flush_idex    <= 1'b0;
         r_bp_upd_valid  <= 1'b0;
         r_bp_upd_pc     <= '0;
         r_bp_upd_taken  <= 1'b0;
         r_bp_upd_target <= '0;
      end else begin
         r_state         <= w_state_next;
         r_redir_pc      <= w_redir_pc_next;
         r_flush_idex    <= w_flush_idex_next;
         r_bp_upd_valid  <= w_bp_upd_valid_next;
         r_bp_upd_pc     <= w_bp_upd_pc_next;
         r_bp_upd_taken  <= w_bp_upd_taken_next;
         r_bp_upd_target <= w_bp_upd_target_next;
      end
   end

   // redir_valid / flush_ifid are decodes of the state register, so there
   // is no combinational path from the ex_* inputs to the redirect outputs.
   assign redir_valid   = (r_state == ST_REDIRECT);
   assign flush_ifid    = (r_state == ST_REDIRECT);
   assign redir_pc      = r_redir_pc;
   assign flush_idex    = r_flush_idex;
   assign bp_upd_valid  = r_bp_upd_valid;
   assign bp_upd_pc     = r_bp_upd_pc;
   assign bp_upd_taken  = r_bp_upd_taken;
   assign bp_upd_target = r_bp_upd_target;

`ifdef BRANCH_REDIRECT_STATS_EN
   // ---------------------------------------------------------------------
   // Statistics counters, updated on the acceptance edge
   // ---------------------------------------------------------------------
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (w_accept) begin
         r_stat_branches <= r_stat_branches + 32'd1;
         if (w_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redir_ready;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        flush_ifid;
   logic        flush_idex;
   logic        bp_upd_valid;
   logic [31:0] bp_upd_pc;
   logic        bp_upd_taken;
   logic [31:0] bp_upd_target;
`ifdef BRANCH_REDIRECT_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int total;
   int bad;

   // Behavioural reference: "a redirect is pending" plus the record that
   // the predictor should see, updated once per clock edge from the rules.
   logic        m_busy;
   logic        m_first;
   logic [31:0] m_pc;
   logic        m_upd_v;
   logic [31:0] m_upd_pc;
   logic        m_upd_taken;
   logic [31:0] m_upd_tgt;
   logic [31:0] m_nbr;
   logic [31:0] m_nmis;

   branch_redirect_ctrl #(.XLEN(32), .INSTR_BYTES(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .redir_ready    (redir_ready),
`ifdef BRANCH_REDIRECT_STATS_EN
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts),
`endif
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .flush_ifid     (flush_ifid),
      .flush_idex     (flush_idex),
      .bp_upd_valid   (bp_upd_valid),
      .bp_upd_pc      (bp_upd_pc),
      .bp_upd_taken   (bp_upd_taken),
      .bp_upd_target  (bp_upd_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0; m_first = 0; m_pc = 0;
      m_upd_v = 0; m_upd_pc = 0; m_upd_taken = 0; m_upd_tgt = 0;
      m_nbr = 0; m_nmis = 0;
   endtask

   task automatic model_edge();
      logic mis;
      if (!m_busy) begin
         m_upd_v = ex_valid;
         if (ex_valid) begin
            m_upd_pc    = ex_pc;
            m_upd_taken = ex_taken;
            m_upd_tgt   = ex_target;
            m_nbr       = m_nbr + 1;
            mis = (ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target));
            if (mis) begin
               m_nmis  = m_nmis + 1;
               m_busy  = 1;
               m_first = 1;
               m_pc    = ex_taken ? ex_target : ex_pc + 32'd4;
            end
         end
      end else begin
         m_upd_v = 0;
         m_first = 0;
         if (redir_ready) m_busy = 0;
      end
   endtask

   // Advance one clock: the model consumes the same inputs the DUT samples.
   task automatic tick();
      if (rst) model_reset(); else model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt,
                        input logic [31:0] ptgt, input logic rdy);
      ex_valid = v; ex_pc = pc; ex_taken = t; ex_target = tgt;
      ex_pred_taken = pt; ex_pred_target = ptgt; redir_ready = rdy;
   endtask

   // Packed views; fields that are don't-care in the current model state
   // are masked so only specified behaviour is compared.
   function automatic logic [100:0] obs_vec();
      obs_vec = {redir_valid, flush_ifid, flush_idex, bp_upd_valid,
                 m_busy ? redir_pc : 32'h0,
                 m_upd_v ? {bp_upd_pc, bp_upd_taken, bp_upd_target} : 65'h0};
   endfunction

   function automatic logic [100:0] exp_vec();
      exp_vec = {m_busy, m_busy, m_busy & m_first, m_upd_v,
                 m_busy ? m_pc : 32'h0,
                 m_upd_v ? {m_upd_pc, m_upd_taken, m_upd_tgt} : 65'h0};
   endfunction

   task automatic test_reset();
      rst = 1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      total++;
      if ({redir_valid, flush_ifid, flush_idex, bp_upd_valid, redir_pc,
           bp_upd_pc, bp_upd_taken, bp_upd_target} !== 101'h0) begin
         $display("FAIL reset_outputs: got %h want 0", {redir_valid, flush_ifid,
                  flush_idex, bp_upd_valid, redir_pc, bp_upd_pc, bp_upd_taken, bp_upd_target});
         bad++;
      end
`ifdef BRANCH_REDIRECT_STATS_EN
      total++;
      if ({stat_branches, stat_mispredicts} !== 64'h0) begin
         $display("FAIL reset_stats: got %h want 0", {stat_branches, stat_mispredicts});
         bad++;
      end
`endif
      tick();
      tick();
      @(negedge clk);
      rst = 0;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
         $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
         bad++;
      end
      $display("test_reset done");
   endtask

   task automatic test_correct_pred();
      drive(1, 32'h100, 1, 32'h200, 1, 32'h200, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      total++;
      if ({redir_valid, flush_ifid, flush_idex, bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target}
          !== {4'b0001, 32'h100, 1'b1, 32'h200}) begin
         $display("FAIL correct_pred: rv=%b fi=%b fx=%b uv=%b upc=%h ut=%b utg=%h want 0 0 0 1 100 1 200",
                  redir_valid, flush_ifid, flush_idex, bp_upd_valid, bp_upd_pc, bp_upd_taken, bp_upd_target);
         bad++;
      end
      tick();
      total++;
      if ({bp_upd_valid, redir_valid} !== 2'b00) begin
         $display("FAIL correct_pred_single_strobe: uv=%b rv=%b want 0 0", bp_upd_valid, redir_valid);
         bad++;
      end
      $display("test_correct_pred done");
   endtask

   task automatic test_not_taken_mispredict();
      drive(1, 32'h100, 0, 32'h180, 1, 32'h180, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      total++;
      if ({redir_valid, flush_ifid, flush_idex, redir_pc, bp_upd_valid, bp_upd_pc, bp_upd_taken}
          !== {3'b111, 32'h104, 1'b1, 32'h100, 1'b0}) begin
         $display("FAIL nt_mispredict: rv=%b fi=%b fx=%b rpc=%h uv=%b upc=%h ut=%b want 1 1 1 104 1 100 0",
                  redir_valid, flush_ifid, flush_idex, redir_pc, bp_upd_valid, bp_upd_pc, bp_upd_taken);
         bad++;
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      total++;
      if ({redir_valid, flush_ifid, flush_idex} !== 3'b000) begin
         $display("FAIL nt_mispredict_release: rv=%b fi=%b fx=%b want 0 0 0",
                  redir_valid, flush_ifid, flush_idex);
         bad++;
      end
      $display("test_not_taken_mispredict done");
   endtask

   task automatic test_jalr_stall();
      drive(1, 32'h400, 1, 32'h3000, 1, 32'h2000, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({redir_valid, redir_pc, flush_ifid, flush_idex, bp_upd_valid}
             !== {1'b1, 32'h3000, 1'b1, (i == 0), (i == 0)}) begin
            $display("FAIL jalr_stall cyc%0d: rv=%b rpc=%h fi=%b fx=%b uv=%b want 1 3000 1 %0d %0d",
                     i, redir_valid, redir_pc, flush_ifid, flush_idex, bp_upd_valid, i == 0, i == 0);
            bad++;
         end
         // Wrong-path instruction arrives at i==1 and must be ignored.
         if (i == 1) drive(1, 32'h500, 0, 32'h0, 1, 32'h600, 0);
         else        drive(0, 0, 0, 0, 0, 0, (i == 3));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      total++;
      if ({redir_valid, flush_ifid, bp_upd_valid} !== 3'b000) begin
         $display("FAIL jalr_stall_release: rv=%b fi=%b uv=%b want 0 0 0",
                  redir_valid, flush_ifid, bp_upd_valid);
         bad++;
      end
      $display("test_jalr_stall done");
   endtask

   task automatic test_wrap();
      drive(1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      total++;
      if ({redir_valid, redir_pc} !== {1'b1, 32'h0}) begin
         $display("FAIL wrap: rv=%b rpc=%h want 1 00000000", redir_valid, redir_pc);
         bad++;
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("test_wrap done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [4];
      pcs = '{32'h1000, 32'h1004, 32'h2000, 32'h2008};
      for (int i = 0; i < 4; i++) begin
         drive(1, pcs[i], i[0], pcs[i] + 32'h40, i[0], pcs[i] + 32'h40, 0);
         tick();
         total++;
         if ({bp_upd_valid, bp_upd_pc, bp_upd_taken, redir_valid}
             !== {1'b1, pcs[i], i[0], 1'b0}) begin
            $display("FAIL back_to_back %0d: uv=%b upc=%h ut=%b rv=%b want 1 %h %b 0",
                     i, bp_upd_valid, bp_upd_pc, bp_upd_taken, redir_valid, pcs[i], i[0]);
            bad++;
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      $display("test_back_to_back done");
   endtask

   task automatic test_random();
      logic [31:0] pc;
      for (int c = 0; c < 500; c++) begin
         pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         drive($urandom_range(0, 2) != 0, pc, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 3)) << 4, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 3)) << 4, 1'($urandom_range(0, 1)));
         tick();
         total++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL random cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
            bad++;
         end
`ifdef BRANCH_REDIRECT_STATS_EN
         total++;
         if ({stat_branches, stat_mispredicts} !== {m_nbr, m_nmis}) begin
            $display("FAIL random_stats cyc%0d: got %0d/%0d want %0d/%0d",
                     c, stat_branches, stat_mispredicts, m_nbr, m_nmis);
            bad++;
         end
`endif
      end
      // Drain any pending redirect.
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      $display("test_random done");
   endtask

   task automatic test_reset_mid_redirect();
      drive(1, 32'h800, 1, 32'h900, 0, 32'h0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      total++;
      if (redir_valid !== 1'b1) begin
         $display("FAIL mid_redirect_setup: rv=%b want 1", redir_valid);
         bad++;
      end
      #2;
      rst = 1;
      model_reset();
      #1;
      total++;
      if ({redir_valid, flush_ifid, flush_idex, bp_upd_valid, redir_pc,
           bp_upd_pc, bp_upd_taken, bp_upd_target} !== 101'h0) begin
         $display("FAIL async_reset: got %h want 0", {redir_valid, flush_ifid,
                  flush_idex, bp_upd_valid, redir_pc, bp_upd_pc, bp_upd_taken, bp_upd_target});
         bad++;
      end
      tick();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({redir_valid, flush_ifid} !== 2'b00) begin
            $display("FAIL post_reset_idle %0d: rv=%b fi=%b want 0 0", i, redir_valid, flush_ifid);
            bad++;
         end
      end
      $display("test_reset_mid_redirect done");
   endtask

`ifdef BRANCH_REDIRECT_STATS_EN
   task automatic test_stats();
      logic mis_pat [5];
      mis_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      rst = 1;
      tick();
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h40 * i, 1, 32'h700, 1, mis_pat[i] ? 32'h800 : 32'h700, 1);
         tick();
         drive(0, 0, 0, 0, 0, 0, 1);
         tick();
      end
      total++;
      if ({stat_branches, stat_mispredicts} !== {32'd5, 32'd2}) begin
         $display("FAIL stats: got %0d/%0d want 5/2", stat_branches, stat_mispredicts);
         bad++;
      end
      $display("test_stats done");
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_correct_pred();
      test_not_taken_mispredict();
      test_jalr_stall();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid_redirect();
`ifdef BRANCH_REDIRECT_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow recovery after the execute-stage branch unit resolves a branch, JAL or JALR.
- Compares the resolved outcome (taken, target) against the fetch-time prediction carried down the pipe. On a mismatch it flushes the wrong-path stages and holds a redirect request to fetch until fetch accepts it.
- Also emits a registered predictor-update record for every resolved control-flow instruction.
- Sits between the EX stage, the IF/ID and ID/EX pipeline registers, the fetch unit and the branch predictor.

Parameters:
- XLEN, 32, datapath and PC width.
- INSTR_BYTES, 4, fall-through increment used for the not-taken correct PC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX holds a resolved branch/JAL/JALR this cycle.
- ex_pc  input  XLEN  PC of the resolved instruction.
- ex_taken  input  1  actual taken outcome from the branch unit (always 1 for jumps).
- ex_target  input  XLEN  actual target from the branch unit.
- ex_pred_taken  input  1  prediction made at fetch.
- ex_pred_target  input  XLEN  predicted target made at fetch.
- redir_ready  input  1  fetch accepts the redirect this cycle.
- redir_valid  output  1  redirect request to fetch.
- redir_pc  output  XLEN  corrected fetch PC; stable while redir_valid=1.
- flush_ifid  output  1  squash the IF/ID register.
- flush_idex  output  1  squash the ID/EX register.
- bp_upd_valid  output  1  predictor update strobe.
- bp_upd_pc  output  XLEN  PC of the updated branch.
- bp_upd_taken  output  1  actual outcome.
- bp_upd_target  output  XLEN  actual target.

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0, including redir_pc, bp_upd_* and the counters.
- A rising rst mid-redirect aborts the redirect immediately. No handshake is owed after reset.
- Correct PC:
  - ex_taken=1: correct PC = ex_target.
  - ex_taken=0: correct PC = ex_pc + INSTR_BYTES, modulo 2^XLEN (wraps at 0xFFFFFFFC -> 0x00000000).
- mispredict = (ex_taken != ex_pred_taken) OR (ex_taken AND ex_pred_taken AND ex_target != ex_pred_target).
- An instruction is accepted when ex_valid=1 and state=IDLE.
- States: IDLE, REDIRECT.
- IDLE:
  - Accepted and mispredict: latch redir_pc=correct PC; next state REDIRECT.
  - Otherwise: stay in IDLE.
- REDIRECT:
  - redir_valid=1 and flush_ifid=1 every cycle.
  - flush_idex=1 in the first REDIRECT cycle only.
  - ex_valid is ignored (wrong path): no update and no new redirect.
  - redir_ready=1 completes the handshake; next state IDLE.
- Latency: detection edge -> redir_valid/flush visible next cycle (registered outputs, no combinational path from ex_* to redir_*/flush_*).
- Minimum REDIRECT occupancy is 1 cycle when redir_ready is already high.
- redir_pc and redir_valid must not change while redir_valid=1 and redir_ready=0.
- Predictor update:
  - Every accepted instruction, mispredicted or not, produces bp_upd_valid=1 for exactly one cycle, the cycle after acceptance, carrying that instruction's ex_pc, ex_taken and ex_target.
  - Back-to-back accepted instructions give back-to-back strobes.
- Simultaneous handshake and ex_valid in the same REDIRECT cycle: ex_valid is dropped. IDLE resumes next cycle.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- When defined, two extra outputs exist:
  - stat_branches (32-bit): increments on every accepted instruction.
  - stat_mispredicts (32-bit): increments on every accepted mispredict.
- Both counters are reset to 0, wrap silently at 2^32, and update on the same edge as acceptance.
- When undefined, neither the ports nor the counter logic exist, and all other behaviour is identical.

Test Plan:
- Reset mid-REDIRECT: induce a mispredict, hold redir_ready=0 for 2 cycles, assert rst -> all outputs 0 asynchronously, state IDLE, no further redir_valid.
- Correct prediction: ex_valid=1, pc=0x100, taken=1, target=0x200, pred_taken=1, pred_target=0x200 -> no redirect, no flush; next cycle bp_upd_valid=1, pc=0x100, target=0x200.
- Not-taken mispredict: pc=0x100, taken=0, pred_taken=1 -> next cycle redir_valid=1, redir_pc=0x104, flush_ifid=1, flush_idex=1. With redir_ready=1 the state returns to IDLE after 1 cycle.
- Target mismatch on JALR with fetch stalled: taken=1, target=0x3000, pred_target=0x2000, redir_ready=0 for 3 cycles -> redir_pc holds 0x3000 and flush_ifid stays high for 4 cycles. flush_idex is high in the first cycle only. A wrong-path ex_valid during the stall produces no bp_upd_valid.
- Wrap-around: pc=0xFFFFFFFC, taken=0, pred_taken=1 -> redir_pc=0x00000000.
- With BRANCH_REDIRECT_STATS_EN: 5 accepted branches, 2 mispredicted -> stat_branches=5, stat_mispredicts=2.
